// File: rtl/genius_pkg.sv
// Shared constants for the Genius game controller: state codes and the
// per-state control word driven towards the datapath.
package genius_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_INIT      = 3'b000,
        S_SETUP     = 3'b001,
        S_PLAY_FPGA = 3'b010,
        S_PLAY_USER = 3'b011,
        S_CHECK     = 3'b100,
        S_NEXT      = 3'b101,
        S_RESULT    = 3'b110
    } state_t;

    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } ctrl_t;

    localparam ctrl_t CTRL_INIT      = '{r1: 1'b1, r2: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_SETUP     = '{e1: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_PLAY_FPGA = '{e3: 1'b1, r2: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_PLAY_USER = '{e2: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_CHECK     = '{e4: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_NEXT      = '{r2: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_RESULT    = '{sel: 1'b1, default: 1'b0};

    // Unused code 111 decodes like S_INIT since the FSM heads there next.
    function automatic ctrl_t ctrl_decode(input logic [STATE_W-1:0] s);
        ctrl_t c;
        case (s)
            S_INIT:      c = CTRL_INIT;
            S_SETUP:     c = CTRL_SETUP;
            S_PLAY_FPGA: c = CTRL_PLAY_FPGA;
            S_PLAY_USER: c = CTRL_PLAY_USER;
            S_CHECK:     c = CTRL_CHECK;
            S_NEXT:      c = CTRL_NEXT;
            S_RESULT:    c = CTRL_RESULT;
            default:     c = CTRL_INIT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Synchronizes the active-low ENTER key and emits a single-cycle pulse on
// each press; a key already held when reset releases is not seen as a press.
module key_edge #(
    parameter int p_sync = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic pulse_o
);

    localparam int VW = p_sync + 1;

    logic [p_sync-1:0] sync_q;
    logic              prev_q;
    logic [VW-1:0]     vld_q;

    // vld_q fills with ones as real key samples replace the reset-level
    // fill, so an edge is only trusted once both compared samples are real.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            vld_q  <= '0;
        end else begin
            sync_q <= p_sync'({sync_q, key_ni});
            prev_q <= sync_q[p_sync-1];
            vld_q  <= VW'({vld_q, 1'b1});
        end
    end

    assign pulse_o = vld_q[VW-1] & prev_q & ~sync_q[p_sync-1];

endmodule

// File: rtl/controle.sv
// Moore controller for the Genius game; control outputs are registered and
// decoded from the next state so they switch together with state_o.
module controle
    import genius_pkg::*;
#(
    parameter int p_state = 3,
    parameter int p_sync  = 2
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               ENTER_N,
    input  logic               end_FPGA,
    input  logic               end_User,
    input  logic               end_time,
    input  logic               win,
    input  logic               match,
    output logic               R1,
    output logic               R2,
    output logic               E1,
    output logic               E2,
    output logic               E3,
    output logic               E4,
    output logic               SEL,
    output logic [p_state-1:0] state_o
);

    localparam logic [p_state-1:0] ST_INIT      = p_state'(S_INIT);
    localparam logic [p_state-1:0] ST_SETUP     = p_state'(S_SETUP);
    localparam logic [p_state-1:0] ST_PLAY_FPGA = p_state'(S_PLAY_FPGA);
    localparam logic [p_state-1:0] ST_PLAY_USER = p_state'(S_PLAY_USER);
    localparam logic [p_state-1:0] ST_CHECK     = p_state'(S_CHECK);
    localparam logic [p_state-1:0] ST_NEXT      = p_state'(S_NEXT);
    localparam logic [p_state-1:0] ST_RESULT    = p_state'(S_RESULT);

    logic               enter_pulse;
    logic [p_state-1:0] state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;

    key_edge #(.p_sync(p_sync)) u_key_edge (
        .clk_i  (CLOCK_50),
        .rst_ni (RESET_N),
        .key_ni (ENTER_N),
        .pulse_o(enter_pulse)
    );

    always_comb begin
        state_d = ST_INIT;
        case (state_q)
            ST_INIT:      state_d = ST_SETUP;
            ST_SETUP:     state_d = enter_pulse ? ST_PLAY_FPGA : ST_SETUP;
            ST_PLAY_FPGA: state_d = end_FPGA ? ST_PLAY_USER : ST_PLAY_FPGA;
            ST_PLAY_USER: begin
                // Timeout takes priority over a simultaneous completed entry.
                if (end_time)      state_d = ST_RESULT;
                else if (end_User) state_d = ST_CHECK;
                else               state_d = ST_PLAY_USER;
            end
            ST_CHECK:     state_d = (match && !win) ? ST_NEXT : ST_RESULT;
            ST_NEXT:      state_d = ST_PLAY_FPGA;
            ST_RESULT:    state_d = enter_pulse ? ST_INIT : ST_RESULT;
            default:      state_d = ST_INIT;
        endcase
        ctrl_d = ctrl_decode(STATE_W'(state_d));
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_INIT;
            ctrl_q  <= CTRL_INIT;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign R1      = ctrl_q.r1;
    assign R2      = ctrl_q.r2;
    assign E1      = ctrl_q.e1;
    assign E2      = ctrl_q.e2;
    assign E3      = ctrl_q.e3;
    assign E4      = ctrl_q.e4;
    assign SEL     = ctrl_q.sel;
    assign state_o = state_q;

endmodule
